mips_cpu_load_unit: RTL and testbench
=====================================

Name: mips_cpu_load_unit

Overview:
- Memory-load stage sitting directly upstream of the register-file write port D.
- Accepts one load request from execute and issues a word-aligned read on the Avalon-style data bus, stalling on waitrequest.
- Extracts, sign- or zero-extends, or merges (LWL/LWR) the returned data, then drives a one-cycle write on port D.
- Little-endian byte lanes; one load in flight at a time.

Parameters:
- MAX_WAIT, 255: maximum consecutive waitrequest cycles before the load is aborted with fault; 0 disables the timeout.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  load request; accepted only when busy=0
- load_type  in  3  0 LB, 1 LH, 2 LWL, 3 LW, 4 LBU, 5 LHU, 6 LWR (opcode[2:0]); 7 is reserved and treated as LW
- addr  in  ADDR_W  effective byte address
- rt_old  in  32  current rt value, merged for LWL/LWR
- dest  in  5  destination register number
- busy  out  1  high from the cycle after acceptance until return to IDLE
- fault  out  1  one-cycle pulse on misalignment or timeout
- mem_address  out  ADDR_W  word-aligned address (addr with [1:0]=0)
- mem_read  out  1  read strobe
- mem_byteenable  out  4  always 4'b1111 while mem_read=1, else 0
- mem_waitrequest  in  1  slave stall
- mem_readdata  in  32  read data, valid when mem_read=1 and waitrequest=0
- write_addr_d  out  5  register-file port D address
- write_enable_d  out  1  register-file port D enable
- write_data_d  out  32  register-file port D data

Behaviour:
- Reset (asynchronous, immediate): state goes to IDLE.
  - busy, fault, mem_read, write_enable_d = 0; mem_byteenable = 0.
  - mem_address, write_addr_d, write_data_d = 0; wait counter = 0.
  - A load in flight is discarded and no write occurs.
- FSM states: IDLE, REQ, WB, FLT.
- IDLE:
  - On start=1, latch load_type, addr, rt_old and dest.
  - If the address is misaligned (see Optional Feature), go to FLT; otherwise go to REQ.
  - start while busy=1 is ignored.
- REQ:
  - mem_read=1 and mem_address held stable.
  - On a posedge with waitrequest=0, capture readdata and go to WB.
  - On a posedge with waitrequest=1, increment the wait counter. When it reaches MAX_WAIT (MAX_WAIT≠0), go to FLT with mem_read dropped.
- WB:
  - write_enable_d=1 for exactly one cycle, unless dest=0 (then 0); write_addr_d=dest.
  - Then go to IDLE.
- FLT: fault=1 for one cycle, no write, then go to IDLE.
- Latency with zero wait states: start accepted at edge N; mem_read high in cycle N+1; write_enable_d high in cycle N+2; busy low from N+3.
- Data formatting, with k=addr[1:0] and byte lane k = readdata[8k+7:8k]:
  - LB/LBU: lane k, sign- or zero-extended.
  - LH/LHU: lanes k+1:k (k∈{0,2}), sign- or zero-extended.
  - LW: the full word.
  - LWL: (word << 8·(3−k)) | (rt_old & ~(0xFFFFFFFF << 8·(3−k))).
  - LWR: (word >> 8·k) | (rt_old & ~(0xFFFFFFFF >> 8·k)).
- write_data_d is registered and holds its value outside WB.
- waitrequest is ignored when mem_read=0.

Optional Feature:
- Macro: MIPS_LOAD_UNIT_ALIGN_CHECK_EN.
- Defined:
  - LH/LHU with addr[0]=1 → FLT.
  - LW with addr[1:0]≠0 → FLT.
  - No bus access and no register write in either case.
- Undefined: misaligned LH/LHU/LW never fault. The low address bits are forced to the natural alignment before lane selection (LH uses k&2; LW uses k=0).
- LB/LBU/LWL/LWR are never misaligned.
- The timeout fault exists in both builds.

Test Plan:
- Memory word 0x8899AABB at 0x1000, zero wait: LB 0x1001 → data 0xFFFFFFAA at cycle N+2; LBU 0x1003 → 0x00000088; LH 0x1002 → 0xFFFF8899; LHU 0x1002 → 0x00008899.
- Same word, rt_old=0x11223344, addr 0x1001: LWL → 0xAABB3344; LWR → 0x118899AA; LW 0x1000 → 0x8899AABB; mem_address=0x1000 in all cases.
- waitrequest high 3 cycles, MAX_WAIT=255, LW dest=5 → mem_read high 4 cycles, one write_enable_d pulse with write_addr_d=5; start pulsed during REQ is ignored.
- MAX_WAIT=4, waitrequest stuck high → fault pulse after 4 wait cycles, no write, busy clears, next load completes normally.
- With macro defined, LW 0x1002 → fault one cycle after acceptance, mem_read never asserted. Without macro, same load → reads 0x1000, writes 0x8899AABB.
- reset driven low while in REQ → mem_read, busy and write_enable_d drop immediately with no clock edge; after release, no write from the aborted load. LW with dest=0 → bus read happens, write_enable_d stays 0.

Source files
------------

// File: rtl/mips_cpu_load_unit.sv
// mips_cpu_load_unit: single-outstanding MIPS load stage feeding register-file port D.
// Define MIPS_LOAD_UNIT_ALIGN_CHECK_EN to fault misaligned LH/LHU/LW instead of forcing alignment.
module mips_cpu_load_unit #(
    parameter int MAX_WAIT = 255,
    parameter int ADDR_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [2:0]        i_load_type,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_rt_old,
    input  logic [4:0]        i_dest,
    output logic              o_busy,
    output logic              o_fault,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_read,
    output logic [3:0]        o_mem_byteenable,
    input  logic              i_mem_waitrequest,
    input  logic [31:0]       i_mem_readdata,
    output logic [4:0]        o_write_addr_d,
    output logic              o_write_enable_d,
    output logic [31:0]       o_write_data_d
);
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WB, FLT} state_t;

    state_t            r_state;
    logic [2:0]        r_type;
    logic [1:0]        r_k;
    logic [31:0]       r_rt;
    logic [4:0]        r_dest;
    logic [CW-1:0]     r_wait;
    logic              r_busy;
    logic              r_fault;
    logic              r_mem_read;
    logic              r_we;
    logic [ADDR_W-1:0] r_maddr;
    logic [4:0]        r_waddr;
    logic [31:0]       r_wdata;

    logic              w_misalign;
    logic [1:0]        w_k;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [4:0]        w_lsh;
    logic [4:0]        w_rsh;
    logic [31:0]       w_data;

`ifdef MIPS_LOAD_UNIT_ALIGN_CHECK_EN
    assign w_misalign = ((i_load_type[1:0] == 2'd1) && i_addr[0]) ||
                        ((i_load_type[1:0] == 2'd3) && (i_addr[1:0] != 2'd0));
`else
    assign w_misalign = 1'b0;
`endif

    // Halfwords use k&2 and words k=0; a no-op when the alignment check is on.
    assign w_k    = (r_type[1:0] == 2'd1) ? {r_k[1], 1'b0} :
                    (r_type[1:0] == 2'd3) ? 2'd0 : r_k;
    assign w_byte = 8'(i_mem_readdata >> {w_k, 3'b000});
    assign w_half = 16'(i_mem_readdata >> {w_k[1], 4'b0000});
    assign w_lsh  = {~w_k, 3'b000};
    assign w_rsh  = {w_k, 3'b000};

    always_comb begin
        w_data = i_mem_readdata;
        case (r_type)
            3'd0: w_data = {{24{w_byte[7]}}, w_byte};
            3'd4: w_data = {24'd0, w_byte};
            3'd1: w_data = {{16{w_half[15]}}, w_half};
            3'd5: w_data = {16'd0, w_half};
            3'd2: w_data = (i_mem_readdata << w_lsh) | (r_rt & ~(32'hFFFF_FFFF << w_lsh));
            3'd6: w_data = (i_mem_readdata >> w_rsh) | (r_rt & ~(32'hFFFF_FFFF >> w_rsh));
            default: w_data = i_mem_readdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_type     <= '0;
            r_k        <= '0;
            r_rt       <= '0;
            r_dest     <= '0;
            r_wait     <= '0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
            r_mem_read <= 1'b0;
            r_we       <= 1'b0;
            r_maddr    <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_fault <= 1'b0;
            r_we    <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_type  <= i_load_type;
                    r_k     <= i_addr[1:0];
                    r_rt    <= i_rt_old;
                    r_dest  <= i_dest;
                    r_maddr <= {i_addr[ADDR_W-1:2], 2'b00};
                    r_wait  <= '0;
                    r_busy  <= 1'b1;
                    if (w_misalign) begin
                        r_fault <= 1'b1;
                        r_state <= FLT;
                    end else begin
                        r_mem_read <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                REQ: if (!i_mem_waitrequest) begin
                    r_mem_read <= 1'b0;
                    r_wdata    <= w_data;
                    r_waddr    <= r_dest;
                    r_we       <= (r_dest != 5'd0);
                    r_state    <= WB;
                end else if (MAX_WAIT != 0 && r_wait == CW'(MAX_WAIT - 1)) begin
                    r_mem_read <= 1'b0;
                    r_fault    <= 1'b1;
                    r_state    <= FLT;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy           = r_busy;
    assign o_fault          = r_fault;
    assign o_mem_address    = r_maddr;
    assign o_mem_read       = r_mem_read;
    assign o_mem_byteenable = {4{r_mem_read}};
    assign o_write_addr_d   = r_waddr;
    assign o_write_enable_d = r_we;
    assign o_write_data_d   = r_wdata;
endmodule

// File: tb/tb_mips_cpu_load_unit.sv
// tb_mips_cpu_load_unit: directed checks of formatting, wait states, timeout, alignment and reset.
module tb_mips_cpu_load_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  load_type = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] rt_old = 32'd0;
    logic [4:0]  dest = 5'd0;
    logic        waitreq = 1'b0;
    logic [31:0] readdata;
    logic        busy, fault, mem_read, we;
    logic [31:0] mem_address, wdata;
    logic [3:0]  byteen;
    logic [4:0]  waddr;

    int checks = 0;
    int errors = 0;

    int          ob_rd, ob_we, ob_we_cyc, ob_flt, ob_flt_cyc, ob_idle, ob_be_bad;
    logic [31:0] ob_data, ob_maddr;
    logic [4:0]  ob_waddr;

    always #5 clk = ~clk;

    assign readdata = (mem_address == 32'h1000) ? 32'h8899_AABB : 32'hDEAD_BEEF;

    mips_cpu_load_unit #(.MAX_WAIT(4), .ADDR_W(32)) dut (
        .i_clk(clk), .i_reset(reset_n), .i_start(start), .i_load_type(load_type),
        .i_addr(addr), .i_rt_old(rt_old), .i_dest(dest), .o_busy(busy), .o_fault(fault),
        .o_mem_address(mem_address), .o_mem_read(mem_read), .o_mem_byteenable(byteen),
        .i_mem_waitrequest(waitreq), .i_mem_readdata(readdata), .o_write_addr_d(waddr),
        .o_write_enable_d(we), .o_write_data_d(wdata)
    );

    // Issues one load and records what the DUT does, cycle c being the c-th negedge after acceptance.
    task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rt,
                            input logic [4:0] d, input int waits, input bit poke);
        ob_rd = 0; ob_we = 0; ob_we_cyc = 0; ob_flt = 0; ob_flt_cyc = 0; ob_idle = 0; ob_be_bad = 0;
        ob_data = 32'h0; ob_maddr = 32'hFFFF_FFFF; ob_waddr = 5'h0;
        @(negedge clk);
        load_type = t; addr = a; rt_old = rt; dest = d; start = 1'b1; waitreq = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && c == 2) begin
                start = 1'b1; dest = 5'd9; load_type = 3'd0; addr = 32'h2001;
            end
            if (byteen !== (mem_read ? 4'hF : 4'h0)) ob_be_bad++;
            if (mem_read) begin
                ob_rd++;
                ob_maddr = mem_address;
            end
            waitreq = mem_read && (ob_rd <= waits);
            if (we) begin
                ob_we++; ob_we_cyc = c; ob_data = wdata; ob_waddr = waddr;
            end
            if (fault) begin
                ob_flt++; ob_flt_cyc = c;
            end
            if (!busy) begin
                ob_idle = c;
                break;
            end
        end
        waitreq = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, fault, mem_read, we, byteen} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b fault=%b rd=%b we=%b be=%h, want all 0", busy, fault, mem_read, we, byteen);
        end
        checks++;
        if ({mem_address, waddr, wdata} !== 69'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h waddr=%0d wdata=%h, want 0", mem_address, waddr, wdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_formatting;
        logic [2:0]  t_v [9]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7, 3'd4};
        logic [31:0] a_v [9]  = '{32'h1001, 32'h1003, 32'h1002, 32'h1002, 32'h1001, 32'h1001, 32'h1000, 32'h1000, 32'h1000};
        logic [31:0] e_v [9]  = '{32'hFFFF_FFAA, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_8899,
                                  32'hAABB_3344, 32'h1188_99AA, 32'h8899_AABB, 32'h8899_AABB, 32'h0000_00BB};
        for (int i = 0; i < 9; i++) begin
            run_load(t_v[i], a_v[i], 32'h1122_3344, 5'(i + 1), 0, 1'b0);
            checks++;
            if (ob_data !== e_v[i] || ob_waddr !== 5'(i + 1)) begin
                errors++;
                $display("FAIL fmt_data[%0d]: got data=%h addr=%0d, want data=%h addr=%0d", i, ob_data, ob_waddr, e_v[i], i + 1);
            end
            checks++;
            if (ob_we != 1 || ob_we_cyc != 2 || ob_idle != 3 || ob_rd != 1) begin
                errors++;
                $display("FAIL fmt_timing[%0d]: got we=%0d@%0d idle=%0d rd=%0d, want we=1@2 idle=3 rd=1", i, ob_we, ob_we_cyc, ob_idle, ob_rd);
            end
            checks++;
            if (ob_maddr !== 32'h1000 || ob_be_bad != 0 || ob_flt != 0) begin
                errors++;
                $display("FAIL fmt_bus[%0d]: got maddr=%h be_bad=%0d flt=%0d, want 00001000 0 0", i, ob_maddr, ob_be_bad, ob_flt);
            end
        end
        @(negedge clk);
        checks++;
        if (wdata !== 32'h0000_00BB || we !== 1'b0) begin
            errors++;
            $display("FAIL data_hold: got wdata=%h we=%b, want 000000bb 0", wdata, we);
        end
    endtask

    task automatic test_wait_states;
        run_load(3'd3, 32'h1000, 32'h0, 5'd5, 3, 1'b1);
        checks++;
        if (ob_rd != 4 || ob_we != 1 || ob_we_cyc != 5 || ob_idle != 6) begin
            errors++;
            $display("FAIL wait3_timing: got rd=%0d we=%0d@%0d idle=%0d, want rd=4 we=1@5 idle=6", ob_rd, ob_we, ob_we_cyc, ob_idle);
        end
        checks++;
        if (ob_waddr !== 5'd5 || ob_data !== 32'h8899_AABB || ob_flt != 0) begin
            errors++;
            $display("FAIL wait3_data: got addr=%0d data=%h flt=%0d, want 5 8899aabb 0", ob_waddr, ob_data, ob_flt);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || mem_read !== 1'b0) begin
                errors++;
                $display("FAIL poke_ignored: got busy=%b rd=%b, want 0 0", busy, mem_read);
            end
        end
    endtask

    task automatic test_timeout;
        run_load(3'd3, 32'h1000, 32'h0, 5'd6, 1000, 1'b0);
        checks++;
        if (ob_rd != 4 || ob_flt != 1 || ob_flt_cyc != 5 || ob_we != 0 || ob_idle != 6) begin
            errors++;
            $display("FAIL timeout: got rd=%0d flt=%0d@%0d we=%0d idle=%0d, want rd=4 flt=1@5 we=0 idle=6", ob_rd, ob_flt, ob_flt_cyc, ob_we, ob_idle);
        end
        run_load(3'd1, 32'h1000, 32'h0, 5'd7, 0, 1'b0);
        checks++;
        if (ob_we != 1 || ob_data !== 32'hFFFF_AABB || ob_flt != 0 || ob_idle != 3) begin
            errors++;
            $display("FAIL after_timeout: got we=%0d data=%h flt=%0d idle=%0d, want 1 ffffaabb 0 3", ob_we, ob_data, ob_flt, ob_idle);
        end
    endtask

    task automatic test_alignment;
        run_load(3'd3, 32'h1002, 32'h0, 5'd8, 0, 1'b0);
`ifdef MIPS_LOAD_UNIT_ALIGN_CHECK_EN
        checks++;
        if (ob_flt != 1 || ob_flt_cyc != 1 || ob_rd != 0 || ob_we != 0 || ob_idle != 2) begin
            errors++;
            $display("FAIL lw_misalign: got flt=%0d@%0d rd=%0d we=%0d idle=%0d, want 1@1 0 0 2", ob_flt, ob_flt_cyc, ob_rd, ob_we, ob_idle);
        end
        run_load(3'd5, 32'h1003, 32'h0, 5'd8, 0, 1'b0);
        checks++;
        if (ob_flt != 1 || ob_rd != 0 || ob_we != 0) begin
            errors++;
            $display("FAIL lhu_misalign: got flt=%0d rd=%0d we=%0d, want 1 0 0", ob_flt, ob_rd, ob_we);
        end
`else
        checks++;
        if (ob_flt != 0 || ob_maddr !== 32'h1000 || ob_we != 1 || ob_data !== 32'h8899_AABB) begin
            errors++;
            $display("FAIL lw_unaligned: got flt=%0d maddr=%h we=%0d data=%h, want 0 00001000 1 8899aabb", ob_flt, ob_maddr, ob_we, ob_data);
        end
        run_load(3'd5, 32'h1003, 32'h0, 5'd8, 0, 1'b0);
        checks++;
        if (ob_flt != 0 || ob_we != 1 || ob_data !== 32'h0000_8899) begin
            errors++;
            $display("FAIL lhu_unaligned: got flt=%0d we=%0d data=%h, want 0 1 00008899", ob_flt, ob_we, ob_data);
        end
`endif
        run_load(3'd6, 32'h1003, 32'hCAFE_F00D, 5'd8, 0, 1'b0);
        checks++;
        if (ob_flt != 0 || ob_we != 1 || ob_data !== 32'hCAFE_F088) begin
            errors++;
            $display("FAIL lwr_k3: got flt=%0d we=%0d data=%h, want 0 1 cafef088", ob_flt, ob_we, ob_data);
        end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        load_type = 3'd3; addr = 32'h1000; dest = 5'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; waitreq = 1'b1;
        checks++;
        if (mem_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: got rd=%b busy=%b, want 1 1", mem_read, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || busy !== 1'b0 || we !== 1'b0 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got rd=%b busy=%b we=%b addr=%h, want 0 0 0 0", mem_read, busy, we, mem_address);
        end
        @(negedge clk);
        reset_n = 1'b1; waitreq = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (we !== 1'b0 || mem_read !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_abort: got we=%b rd=%b busy=%b, want 0 0 0", we, mem_read, busy);
            end
        end
    endtask

    task automatic test_dest_zero;
        run_load(3'd3, 32'h1000, 32'h0, 5'd0, 0, 1'b0);
        checks++;
        if (ob_rd != 1 || ob_we != 0 || ob_idle != 3 || ob_flt != 0) begin
            errors++;
            $display("FAIL dest_zero: got rd=%0d we=%0d idle=%0d flt=%0d, want 1 0 3 0", ob_rd, ob_we, ob_idle, ob_flt);
        end
    endtask

    initial begin
        test_reset();
        test_formatting();
        test_wait_states();
        test_timeout();
        test_alignment();
        test_reset_abort();
        test_dest_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
